// File: rtl/tz_time_counter.sv
// +---------------------------------------------------------------------------+
// | tz_time_counter                                                           |
// | GMT hour/min/sec counter with prescaler; signed timezone on display path. |
// | Optional 12 h display: define CLK_12H_EN (adds MODE_12H / PM).            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tz_time_counter #(
  parameter int         CLK_HZ      = 1000,
  parameter int         TZ_MIN      = -12,
  parameter int         TZ_MAX      = 14,
  parameter int         TZ_DEFAULT  = 9,
  parameter logic [3:0] ST_RUN      = 4'd0,
  parameter logic [3:0] ST_TIME_SET = 4'd1,
  parameter logic [3:0] ST_TZ_SETUP = 4'd2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  STATE,
  input  logic        LOAD,
  input  logic [17:0] LOAD_DATA,
  input  logic        TZ_UP,
  input  logic        TZ_DN,
  output logic [17:0] DATA,
  output logic [4:0]  TZ,
  output logic        TICK,
  output logic        DAY_WRAP,
  output logic        LOAD_ERR
`ifdef CLK_12H_EN
  ,
  input  logic        MODE_12H,
  output logic        PM
`endif
);

  localparam int               C_PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [C_PW-1:0]  C_PS_LAST    = C_PW'(CLK_HZ - 1);
  localparam int               C_TZ_DEF_MOD = ((TZ_DEFAULT % 24) + 24) % 24;
  localparam logic signed [4:0] C_TZ_DEF    = 5'(TZ_DEFAULT);
  localparam logic signed [4:0] C_TZ_MIN    = 5'(TZ_MIN);
  localparam logic signed [4:0] C_TZ_MAX    = 5'(TZ_MAX);

  // Folds a value in -24..47 into 0..23.
  function automatic logic [5:0] f_fold24(input logic signed [7:0] v);
    logic signed [7:0] t;
    t = v;
    if (t < 0)
      t = t + 8'sd24;
    else if (t >= 24)
      t = t - 8'sd24;
    return t[5:0];
  endfunction

  logic [C_PW-1:0]   r_presc;
  logic [5:0]        r_hour;
  logic [5:0]        r_min;
  logic [5:0]        r_sec;
  logic signed [4:0] r_tz;
  logic              r_tick;
  logic              r_wrap;
  logic              r_ld_err;

  logic              w_mode_set;
  logic              w_mode_tz;
  logic              w_mode_run;
  logic              w_count;
  logic              w_tick;
  logic              w_end_of_day;
  logic signed [7:0] w_tz_ext;
  logic [5:0]        w_local_hr;
  logic [5:0]        w_disp_hr;
  logic [5:0]        w_ld_hr;
  logic [5:0]        w_ld_min;
  logic [5:0]        w_ld_sec;
  logic              w_ld_ok;
  logic [5:0]        w_ld_gmt_hr;

  // Unrecognised STATE codes fall back to run behaviour.
  assign w_mode_set   = (STATE == ST_TIME_SET);
  assign w_mode_tz    = (STATE == ST_TZ_SETUP);
  assign w_mode_run   = (STATE == ST_RUN) | ~(w_mode_set | w_mode_tz);
  assign w_count      = w_mode_run | w_mode_tz;
  assign w_tick       = w_count & (r_presc == C_PS_LAST);
  assign w_end_of_day = (r_hour == 6'd23) & (r_min == 6'd59) & (r_sec == 6'd59);

  assign w_tz_ext     = {{3{r_tz[4]}}, r_tz};
  assign w_local_hr   = f_fold24($signed({2'b00, r_hour}) + w_tz_ext);

  assign w_ld_hr      = LOAD_DATA[17:12];
  assign w_ld_min     = LOAD_DATA[11:6];
  assign w_ld_sec     = LOAD_DATA[5:0];
  assign w_ld_ok      = (w_ld_hr <= 6'd23) & (w_ld_min <= 6'd59) & (w_ld_sec <= 6'd59);
  assign w_ld_gmt_hr  = f_fold24($signed({2'b00, w_ld_hr}) - w_tz_ext);

`ifdef CLK_12H_EN
  always_comb begin
    w_disp_hr = w_local_hr;
    if (MODE_12H) begin
      if (w_local_hr == 6'd0)
        w_disp_hr = 6'd12;
      else if (w_local_hr > 6'd12)
        w_disp_hr = w_local_hr - 6'd12;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      PM <= 1'b0;
    else
      PM <= MODE_12H & (w_local_hr >= 6'd12);
  end
`else
  assign w_disp_hr = w_local_hr;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc  <= '0;
      r_hour   <= 6'd0;
      r_min    <= 6'd0;
      r_sec    <= 6'd0;
      r_tz     <= C_TZ_DEF;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
      DATA     <= {6'(C_TZ_DEF_MOD), 12'd0};
    end else begin
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
      DATA     <= {w_disp_hr, r_min, r_sec};

      if (!w_count) begin
        r_presc <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
        r_wrap  <= w_end_of_day;
        if (r_sec == 6'd59) begin
          r_sec <= 6'd0;
          if (r_min == 6'd59) begin
            r_min  <= 6'd0;
            r_hour <= (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_mode_tz) begin
        if (TZ_UP && !TZ_DN && (r_tz < C_TZ_MAX))
          r_tz <= r_tz + 5'sd1;
        else if (TZ_DN && !TZ_UP && (r_tz > C_TZ_MIN))
          r_tz <= r_tz - 5'sd1;
      end

      // Time-set mode never ticks, so a load cannot collide with the cascade.
      if (w_mode_set && LOAD) begin
        if (w_ld_ok) begin
          r_hour  <= w_ld_gmt_hr;
          r_min   <= w_ld_min;
          r_sec   <= w_ld_sec;
          r_presc <= '0;
        end else begin
          r_ld_err <= 1'b1;
        end
      end
    end
  end

  assign TZ       = r_tz;
  assign TICK     = r_tick;
  assign DAY_WRAP = r_wrap;
  assign LOAD_ERR = r_ld_err;

endmodule

`default_nettype wire

// File: tb/tb_tz_time_counter.sv
// Bench for tz_time_counter: directed scenarios plus random stimulus,
// checked every cycle against a seconds-of-day reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_tz_time_counter;

  localparam int HZ = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  STATE;
  logic        LOAD;
  logic [17:0] LOAD_DATA;
  logic        TZ_UP;
  logic        TZ_DN;
  logic [17:0] DATA;
  logic [4:0]  TZ;
  logic        TICK;
  logic        DAY_WRAP;
  logic        LOAD_ERR;
`ifdef CLK_12H_EN
  logic        MODE_12H;
  logic        PM;
`endif

  tz_time_counter #(.CLK_HZ(HZ)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .STATE     (STATE),
    .LOAD      (LOAD),
    .LOAD_DATA (LOAD_DATA),
    .TZ_UP     (TZ_UP),
    .TZ_DN     (TZ_DN),
    .DATA      (DATA),
    .TZ        (TZ),
    .TICK      (TICK),
    .DAY_WRAP  (DAY_WRAP),
    .LOAD_ERR  (LOAD_ERR)
`ifdef CLK_12H_EN
    ,
    .MODE_12H  (MODE_12H),
    .PM        (PM)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: GMT as seconds of day, offset in hours, prescale phase.
  int          m_gmt, m_tz, m_phase;
  logic [17:0] m_data;
  logic        m_tick, m_wrap, m_err;

  int cyc = 0;
  int last_tick = -1;
  bit gap_track = 1'b0;
  bit chk_data  = 1'b1;
  int n_wrap = 0;
  int n_tick = 0;

  function automatic logic [17:0] disp(input int g, input int t);
    int h;
    h = (((g / 3600) + t) % 24 + 24) % 24;
    return {6'(h), 6'((g / 60) % 60), 6'(g % 60)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic [17:0] nd;
    int h, mi, s;
    @(posedge CLK);
    if (RESET) begin
      m_gmt = 0; m_tz = 9; m_phase = 0;
      m_data = {6'd9, 12'd0};
      m_tick = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    end else begin
      nd = disp(m_gmt, m_tz);
      m_tick = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
      if (STATE == 4'd1) begin
        m_phase = 0;
      end else if (m_phase == HZ - 1) begin
        m_phase = 0;
        m_tick  = 1'b1;
        m_wrap  = (m_gmt == 86399);
        m_gmt   = (m_gmt + 1) % 86400;
      end else begin
        m_phase++;
      end
      if (STATE == 4'd2) begin
        if (TZ_UP && !TZ_DN && m_tz < 14) m_tz++;
        else if (TZ_DN && !TZ_UP && m_tz > -12) m_tz--;
      end
      if (STATE == 4'd1 && LOAD) begin
        h  = int'(LOAD_DATA[17:12]);
        mi = int'(LOAD_DATA[11:6]);
        s  = int'(LOAD_DATA[5:0]);
        if (h <= 23 && mi <= 59 && s <= 59)
          m_gmt = (((h - m_tz) % 24 + 24) % 24) * 3600 + mi * 60 + s;
        else
          m_err = 1'b1;
      end
      m_data = nd;
    end
    #1;
    cyc++;
    if (chk_data) chk("DATA", DATA, m_data);
    chk("TZ", TZ, m_tz[4:0]);
    chk("TICK", TICK, m_tick);
    chk("DAY_WRAP", DAY_WRAP, m_wrap);
    chk("LOAD_ERR", LOAD_ERR, m_err);
    if (DAY_WRAP) n_wrap++;
    if (TICK) begin
      n_tick++;
      if (gap_track && last_tick >= 0) chk("TICK_GAP", cyc - last_tick, HZ);
      last_tick = cyc;
    end
  endtask

  task automatic load(input int h, input int mi, input int s);
    LOAD_DATA = {6'(h), 6'(mi), 6'(s)};
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  task automatic pulse_tz(input bit up, input bit dn);
    TZ_UP = up; TZ_DN = dn;
    step();
    TZ_UP = 1'b0; TZ_DN = 1'b0;
    step();
  endtask

  initial begin
    int r;
    RESET = 1'b1; STATE = 4'd0; LOAD = 1'b0; LOAD_DATA = '0;
    TZ_UP = 1'b0; TZ_DN = 1'b0;
`ifdef CLK_12H_EN
    MODE_12H = 1'b0;
`endif
    repeat (3) step();
    RESET = 1'b0;
    step();
    chk("RST_DATA", DATA, {6'd9, 12'd0});
    chk("RST_TZ", TZ, 5'd9);

    // Day wrap: local 08:59:50 with TZ=9 is GMT 23:59:50
    STATE = 4'd1;
    load(8, 59, 50);
    STATE = 4'd0;
    gap_track = 1'b1; last_tick = -1; n_wrap = 0;
    repeat (HZ * 12) step();
    chk("WRAP_COUNT", n_wrap, 1);
    chk("WRAP_HOUR", DATA[17:12], 6'd9);
    gap_track = 1'b0;

    // Reset mid-prescale at GMT 05:10:20
    STATE = 4'd1;
    load(14, 10, 20);
    STATE = 4'd0;
    repeat (2) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("MIDRST_DATA", DATA, {6'd9, 12'd0});
    chk("MIDRST_TZ", TZ, 5'd9);

    // Timezone saturation
    STATE = 4'd2;
    repeat (30) pulse_tz(1'b1, 1'b0);
    chk("TZ_SAT_HI", TZ, 5'd14);
    repeat (40) pulse_tz(1'b0, 1'b1);
    chk("TZ_SAT_LO", TZ, 5'b10100);
    pulse_tz(1'b1, 1'b1);
    chk("TZ_BOTH", TZ, 5'b10100);
    STATE = 4'd1;
    load(15, 0, 0);
    step();
    chk("TZM12_HOUR", DATA[17:12], 6'd15);

    // Time load with TZ=9
    RESET = 1'b1; step(); RESET = 1'b0;
    STATE = 4'd1;
    load(2, 30, 0);
    n_tick = 0;
    repeat (3 * HZ) step();
    chk("LOAD_DATA", DATA, {6'd2, 6'd30, 6'd0});
    chk("SET_NO_TICK", n_tick, 0);
    load(24, 0, 0);
    chk("LOAD_ERR_PULSE", LOAD_ERR, 1'b1);
    step();
    chk("LOAD_ERR_KEEP", DATA, {6'd2, 6'd30, 6'd0});
    STATE = 4'd0;
    load(1, 1, 1);
    chk("RUN_LOAD_NOERR", LOAD_ERR, 1'b0);
    STATE = 4'd2;
    pulse_tz(1'b0, 1'b1);
    chk("GMT17_VIA_TZ8", DATA[17:12], 6'd1);

    // Switch RUN -> TZ_SETUP with prescaler at 2
    STATE = 4'd0;
    gap_track = 1'b1; last_tick = -1;
    repeat (2 * HZ) step();
    for (int k = 0; k < 2 * HZ && m_phase != 2; k++) step();
    STATE = 4'd2;
    n_tick = 0;
    repeat (5 * HZ) step();
    chk("TZSETUP_TICKS", n_tick, 5);
    gap_track = 1'b0;

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      STATE = (r < 60) ? 4'd0 : (r < 75) ? 4'd1 : (r < 92) ? 4'd2 : 4'($urandom_range(3, 15));
      TZ_UP = ($urandom_range(0, 4) == 0);
      TZ_DN = ($urandom_range(0, 4) == 0);
      LOAD  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        LOAD_DATA = {6'((((23 + m_tz) % 24) + 24) % 24), 6'd59, 6'($urandom_range(40, 59))};
      else
        LOAD_DATA = {6'($urandom_range(0, 25)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
      RESET = ($urandom_range(0, 299) == 0);
      step();
    end
    RESET = 1'b0; LOAD = 1'b0; TZ_UP = 1'b0; TZ_DN = 1'b0;

`ifdef CLK_12H_EN
    RESET = 1'b1; step(); RESET = 1'b0;
    chk_data = 1'b0;
    MODE_12H = 1'b1;
    STATE = 4'd1;
    load(0, 15, 0);
    step();
    chk("H12_MIDNIGHT", DATA, {6'd12, 6'd15, 6'd0});
    chk("H12_MIDNIGHT_PM", PM, 1'b0);
    load(13, 0, 0);
    step();
    chk("H12_13", DATA[17:12], 6'd1);
    chk("H12_13_PM", PM, 1'b1);
    load(12, 0, 0);
    step();
    chk("H12_NOON", DATA[17:12], 6'd12);
    chk("H12_NOON_PM", PM, 1'b1);
    MODE_12H = 1'b0;
    step();
    chk("H24_BACK", DATA[17:12], 6'd12);
    chk("H24_BACK_PM", PM, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
